cache_direct_param: RTL and testbench
=====================================

Name: cache_direct_param

Overview:
- Parametrised direct-mapped instruction cache; successor to the 8-line, 1-word-per-line cache.
- Sits between the IF-stage PC and main memory (MM). Gives a zero-latency hit path, drives HitWrite as the PCWrite/IFIDWrite stall control, and runs a multi-word line refill from MM through a req/valid handshake.
- Adds flush and saturating hit/miss counters.

Parameters:
LINES, 8, number of cache lines; power of two, >=2
WORDS_PER_LINE, 4, 32-bit words per line; power of two, >=1
CNT_W, 20, width of hit/miss counters

Ports:
CLK  in  1  clock, rising edge
RESET  in  1  asynchronous, active-high reset
PC  in  32  fetch address; PC[1:0] ignored
Req  in  1  fetch request valid; held with stable PC until HitWrite=1
Flush  in  1  invalidate all lines
HitWrite  out  1  1 = Data_Cache valid this cycle (PCWrite/IFIDWrite enable)
Data_Cache  out  32  fetched instruction word
MM_Req  out  1  MM word-read request
MM_Addr  out  32  MM word address (byte address, [1:0]=0)
MM_Valid  in  1  MM returns Data_MM for the current MM_Addr this cycle
Data_MM  in  32  MM read data
CNT_HIT  out  CNT_W  hit counter
CNT_MISS  out  CNT_W  miss counter

Behaviour:
- Address split:
  - OFF = log2(WORDS_PER_LINE), IDX = log2(LINES).
  - word = PC[2+OFF-1:2], index = PC[2+OFF+IDX-1:2+OFF], tag = PC[31:2+OFF+IDX].
  - Line storage: valid bit, tag, WORDS_PER_LINE data words.
- Reset (async, RESET=1): state=IDLE, all valid=0, CNT_HIT=0, CNT_MISS=0, word counter=0, MM_Req=0, MM_Addr=0, HitWrite=0, Data_Cache=0. Tag/data contents don't care. Reset mid-refill aborts the refill; the line stays invalid.
- FSM states: IDLE, REFILL, RESPOND.
- IDLE:
  - HitWrite and Data_Cache are combinational from PC and the arrays.
  - Hit = Req & valid[index] & tag match. On hit: HitWrite=1, Data_Cache = line[index].word[word], and CNT_HIT+1 at the edge.
  - Miss (Req & !hit & !Flush): HitWrite=0, Data_Cache holds its last value, CNT_MISS+1. Latch base = {PC[31:2+OFF], OFF+2 zeros}, clear valid[index], word counter=0, next state REFILL.
  - Req=0: HitWrite=0, no counter change.
- REFILL:
  - MM_Req=1, MM_Addr = base + 4*counter, HitWrite=0.
  - On each MM_Valid: write Data_MM into line[index].word[counter]; counter+1 (wraps mod WORDS_PER_LINE).
  - When MM_Valid arrives with counter=WORDS_PER_LINE-1: set valid[index]=1, write tag, go to RESPOND; MM_Req=0 from the next cycle.
  - MM_Valid=0 cycles: hold state. No timeout.
- RESPOND (1 cycle):
  - HitWrite=1, Data_Cache = filled word at PC word offset. No counter change. Next state IDLE.
  - Miss latency = WORDS_PER_LINE MM beats + 1 cycle.
- Flush:
  - In IDLE: all valid bits cleared at the edge. Flush has priority over lookup: HitWrite=0 that cycle, no counter change, no refill start.
  - In REFILL/RESPOND: latched as pending. Applied on the first IDLE cycle with the same priority rule, so the just-filled line is invalidated after its RESPOND.
- Counters saturate at 2^CNT_W-1; no wrap.
- MM_Valid outside REFILL is ignored.

Test Plan:
- Reset then Req, PC=0x0000_0040 (LINES=8, WPL=4) -> miss: CNT_MISS=1; MM_Addr sequence 0x40,0x44,0x48,0x4C with 1-cycle MM_Valid; RESPOND HitWrite=1 with Data_MM of beat 0.
- After fill, PC=0x4C -> same-cycle HitWrite=1, beat-3 data, CNT_HIT=1; PC=0x48 -> CNT_HIT=2.
- Conflict: fill 0x40, then PC=0x240 (same index, different tag) -> miss, refill 0x240..0x24C; PC=0x40 -> miss again, CNT_MISS=3.
- MM stalls 3 cycles between beats -> MM_Addr/MM_Req stable, HitWrite=0 throughout, data correct.
- Flush asserted in IDLE after fill -> next PC=0x40 misses; Flush during REFILL -> RESPOND still HitWrite=1, then following Req to same PC misses.
- RESET pulsed mid-refill (after beat 1) -> MM_Req=0 immediately, counters 0, re-request of same PC misses and refills all 4 words.

Source files
------------

// File: rtl/cache_direct_param.sv
// Parametrised direct-mapped instruction cache with a zero-latency hit path,
// multi-word line refill from main memory, deferred flush and saturating hit/miss counters.
//
// state   | meaning
// IDLE    | lookup; hit answers combinationally, miss starts a refill
// REFILL  | fetching WORDS_PER_LINE words from MM, one per MM_Valid
// RESPOND | one cycle presenting the freshly filled word
module cache_direct_param #(
  parameter int LINES          = 8,
  parameter int WORDS_PER_LINE = 4,
  parameter int CNT_W          = 20
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic [31:0]      PC,
  input  logic             Req,
  input  logic             Flush,
  output logic             HitWrite,
  output logic [31:0]      Data_Cache,
  output logic             MM_Req,
  output logic [31:0]      MM_Addr,
  input  logic             MM_Valid,
  input  logic [31:0]      Data_MM,
  output logic [CNT_W-1:0] CNT_HIT,
  output logic [CNT_W-1:0] CNT_MISS
);

  localparam int OFF   = $clog2(WORDS_PER_LINE);
  localparam int IDX   = $clog2(LINES);
  localparam int WW    = (OFF > 0) ? OFF : 1;
  localparam int TW    = 32 - 2 - OFF - IDX;
  localparam int DEPTH = LINES * WORDS_PER_LINE;
  localparam int AW    = IDX + OFF;

  typedef enum logic [1:0] {IDLE, REFILL, RESPOND} state_t;

  state_t state, state_nxt;

  logic [WW-1:0]  pc_word;
  logic [IDX-1:0] pc_idx;
  logic [TW-1:0]  pc_tag;

  logic [LINES-1:0] valid;
  logic [TW-1:0]    tag_mem  [LINES];
  logic [31:0]      data_mem [DEPTH];

  logic [31:0]      base;
  logic [IDX-1:0]   refill_idx;
  logic [TW-1:0]    refill_tag;
  logic [WW-1:0]    wcnt;
  logic             flush_pend;
  logic [31:0]      data_q;
  logic [CNT_W-1:0] cnt_hit, cnt_miss;

  logic        flush_eff, hit, do_hit, do_miss, do_flush, fill_beat, fill_last;
  logic [31:0] rd_word;
  logic        unused_ok;

  generate
    if (OFF > 0) begin : g_word
      assign pc_word = PC[2+OFF-1:2];
    end else begin : g_noword
      assign pc_word = '0;
    end
  endgenerate

  assign pc_idx    = PC[2+OFF+IDX-1:2+OFF];
  assign pc_tag    = PC[31:2+OFF+IDX];
  assign unused_ok = ^PC[1:0];

  function automatic logic [AW-1:0] waddr(input logic [IDX-1:0] idx, input logic [WW-1:0] word);
    return (AW'(idx) << OFF) | AW'(word);
  endfunction

  assign flush_eff = Flush | flush_pend;
  assign hit       = Req & valid[pc_idx] & (tag_mem[pc_idx] == pc_tag);
  // RESPOND reads the line being filled; PC is still held, so its word offset is valid
  assign rd_word   = data_mem[waddr((state == RESPOND) ? refill_idx : pc_idx, pc_word)];

  always_comb begin
    state_nxt  = state;
    HitWrite   = 1'b0;
    Data_Cache = data_q;
    MM_Req     = 1'b0;
    MM_Addr    = '0;
    do_hit     = 1'b0;
    do_miss    = 1'b0;
    do_flush   = 1'b0;
    fill_beat  = 1'b0;
    fill_last  = 1'b0;
    case (state)
      IDLE: begin
        if (flush_eff) begin
          do_flush = 1'b1;
        end else if (hit) begin
          HitWrite   = 1'b1;
          Data_Cache = rd_word;
          do_hit     = 1'b1;
        end else if (Req) begin
          do_miss   = 1'b1;
          state_nxt = REFILL;
        end
      end
      REFILL: begin
        MM_Req  = 1'b1;
        MM_Addr = base | (32'(wcnt) << 2);
        if (MM_Valid) begin
          fill_beat = 1'b1;
          if (wcnt == WW'(WORDS_PER_LINE - 1)) begin
            fill_last = 1'b1;
            state_nxt = RESPOND;
          end
        end
      end
      RESPOND: begin
        HitWrite   = 1'b1;
        Data_Cache = rd_word;
        state_nxt  = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state      <= IDLE;
      valid      <= '0;
      base       <= '0;
      refill_idx <= '0;
      refill_tag <= '0;
      wcnt       <= '0;
      flush_pend <= 1'b0;
      data_q     <= '0;
      cnt_hit    <= '0;
      cnt_miss   <= '0;
    end else begin
      state <= state_nxt;
      if (HitWrite) data_q <= Data_Cache;
      if (Flush && state != IDLE) flush_pend <= 1'b1;
      else if (do_flush)          flush_pend <= 1'b0;
      if (do_flush) valid <= '0;
      if (do_miss) begin
        valid[pc_idx] <= 1'b0;
        base          <= {PC[31:2+OFF], {(OFF+2){1'b0}}};
        refill_idx    <= pc_idx;
        refill_tag    <= pc_tag;
        wcnt          <= '0;
      end
      if (fill_beat) wcnt <= fill_last ? '0 : wcnt + 1'b1;
      if (fill_last) valid[refill_idx] <= 1'b1;
      if (do_hit && cnt_hit != '1)   cnt_hit  <= cnt_hit + 1'b1;
      if (do_miss && cnt_miss != '1) cnt_miss <= cnt_miss + 1'b1;
    end
  end

  // Array contents are don't-care after reset, so they carry no reset
  always_ff @(posedge CLK) begin
    if (fill_beat) data_mem[waddr(refill_idx, wcnt)] <= Data_MM;
    if (fill_last) tag_mem[refill_idx] <= refill_tag;
  end

  assign CNT_HIT  = cnt_hit;
  assign CNT_MISS = cnt_miss;

endmodule

// File: tb/tb_cache_direct_param.sv
// Randomised bench for cache_direct_param against a line-level reference model
// (valid + line base address per index, memory contents from a fixed address hash).
module tb_cache_direct_param;

  localparam int LINES   = 8;
  localparam int WPL     = 4;
  localparam int CNT_W   = 6;
  localparam int CNT_MAX = (1 << CNT_W) - 1;
  localparam int LBYTES  = 4 * WPL;

  logic             CLK = 1'b0;
  logic             RESET;
  logic [31:0]      PC;
  logic             Req, Flush;
  logic             HitWrite;
  logic [31:0]      Data_Cache;
  logic             MM_Req;
  logic [31:0]      MM_Addr;
  logic             MM_Valid;
  logic [31:0]      Data_MM;
  logic [CNT_W-1:0] CNT_HIT, CNT_MISS;

  cache_direct_param #(.LINES(LINES), .WORDS_PER_LINE(WPL), .CNT_W(CNT_W)) dut (
    .CLK(CLK), .RESET(RESET), .PC(PC), .Req(Req), .Flush(Flush),
    .HitWrite(HitWrite), .Data_Cache(Data_Cache), .MM_Req(MM_Req), .MM_Addr(MM_Addr),
    .MM_Valid(MM_Valid), .Data_MM(Data_MM), .CNT_HIT(CNT_HIT), .CNT_MISS(CNT_MISS)
  );

  always #5 CLK = ~CLK;

  int n_checks = 0;
  int n_pass   = 0;

  bit          m_valid [LINES];
  logic [31:0] m_base  [LINES];
  int          m_hit, m_miss;
  logic [31:0] m_last;
  bit          m_pend;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) $display("FAIL %s: got %h expected %h", tag, got, exp);
    else n_pass++;
  endtask

  function automatic logic [31:0] mm_data(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h1234_5678;
  endfunction

  function automatic logic [31:0] line_of(input logic [31:0] pc);
    return (pc / LBYTES) * LBYTES;
  endfunction

  function automatic int idx_of(input logic [31:0] pc);
    return int'((pc / LBYTES) % LINES);
  endfunction

  task automatic model_reset();
    for (int i = 0; i < LINES; i++) m_valid[i] = 0;
    m_hit = 0; m_miss = 0; m_last = '0; m_pend = 0;
  endtask

  task automatic chk_cnt();
    chk("cnt_hit", 32'(CNT_HIT), m_hit);
    chk("cnt_miss", 32'(CNT_MISS), m_miss);
  endtask

  task automatic chk_reset_outputs();
    chk("rst_hitwrite", 32'(HitWrite), 0);
    chk("rst_data", Data_Cache, 0);
    chk("rst_mm_req", 32'(MM_Req), 0);
    chk("rst_mm_addr", MM_Addr, 0);
    chk_cnt();
  endtask

  task automatic clear_all_valid();
    for (int i = 0; i < LINES; i++) m_valid[i] = 0;
  endtask

  task automatic idle_cycle();
    Req = 0; PC = $urandom; Flush = 0; MM_Valid = 1'($urandom); Data_MM = $urandom;
    @(negedge CLK);
    chk("idle_hitwrite", 32'(HitWrite), 0);
    chk("idle_mm_req", 32'(MM_Req), 0);
    @(posedge CLK); #1;
    chk_cnt();
  endtask

  task automatic idle_flush();
    Req = 1'($urandom); PC = $urandom; Flush = 1; MM_Valid = 0;
    @(negedge CLK);
    chk("flush_hitwrite", 32'(HitWrite), 0);
    @(posedge CLK); #1;
    Flush = 0; Req = 0;
    clear_all_valid();
    chk_cnt();
  endtask

  // flush_beat / abort_beat: beat index at which Flush is raised / RESET is pulsed after; -1 = none
  task automatic fetch(input logic [31:0] pc, input int st_lo, input int st_hi,
                       input int flush_beat, input int abort_beat);
    int          idx;
    logic [31:0] lb, exp;
    bit          was_hit;
    idx = idx_of(pc);
    lb  = line_of(pc);
    exp = mm_data({pc[31:2], 2'b00});
    PC = pc; Req = 1; Flush = 0; MM_Valid = 1'($urandom); Data_MM = $urandom;
    @(negedge CLK);
    was_hit = m_valid[idx] && (m_base[idx] == lb);
    chk("lookup_hitwrite", 32'(HitWrite), 32'(was_hit));
    chk("lookup_mm_req", 32'(MM_Req), 0);
    if (was_hit) begin
      chk("hit_data", Data_Cache, exp);
      m_last = exp;
    end else begin
      chk("miss_data_hold", Data_Cache, m_last);
    end
    @(posedge CLK); #1;
    if (was_hit) begin
      if (m_hit < CNT_MAX) m_hit++;
      chk_cnt();
      Req = 0; MM_Valid = 0;
      return;
    end
    if (m_miss < CNT_MAX) m_miss++;
    m_valid[idx] = 0;
    chk_cnt();
    for (int b = 0; b < WPL; b++) begin
      int stalls;
      stalls = int'($urandom_range(st_hi, st_lo));
      for (int s = 0; s < stalls; s++) begin
        MM_Valid = 0; Data_MM = $urandom; Flush = 0;
        @(negedge CLK);
        chk("stall_mm_req", 32'(MM_Req), 1);
        chk("stall_mm_addr", MM_Addr, lb + 4 * b);
        chk("stall_hitwrite", 32'(HitWrite), 0);
        @(posedge CLK); #1;
      end
      MM_Valid = 1; Data_MM = mm_data(lb + 4 * b); Flush = (b == flush_beat);
      @(negedge CLK);
      chk("beat_mm_req", 32'(MM_Req), 1);
      chk("beat_mm_addr", MM_Addr, lb + 4 * b);
      chk("beat_hitwrite", 32'(HitWrite), 0);
      @(posedge CLK); #1;
      if (Flush) m_pend = 1;
      Flush = 0; MM_Valid = 0;
      if (b == abort_beat) begin
        RESET = 1; #1;
        model_reset();
        chk_reset_outputs();
        @(posedge CLK); #1;
        RESET = 0; Req = 0;
        return;
      end
    end
    MM_Valid = 1'($urandom); Data_MM = $urandom;
    @(negedge CLK);
    chk("respond_hitwrite", 32'(HitWrite), 1);
    chk("respond_data", Data_Cache, exp);
    chk("respond_mm_req", 32'(MM_Req), 0);
    m_last = exp;
    @(posedge CLK); #1;
    m_valid[idx] = 1;
    m_base[idx]  = lb;
    chk_cnt();
    MM_Valid = 0;
    if (m_pend) begin
      @(negedge CLK);
      chk("pend_flush_hitwrite", 32'(HitWrite), 0);
      @(posedge CLK); #1;
      clear_all_valid();
      m_pend = 0;
      chk_cnt();
    end
    Req = 0;
  endtask

  function automatic logic [31:0] rand_pc();
    logic [31:0] p;
    p = ($urandom % 4) * 128 + ($urandom % LINES) * LBYTES + ($urandom % WPL) * 4 + ($urandom % 4);
    if ($urandom % 8 == 0) p = p | 32'hF000_0000;
    return p;
  endfunction

  initial begin
    RESET = 1; PC = '0; Req = 0; Flush = 0; MM_Valid = 0; Data_MM = '0;
    model_reset();
    #12;
    chk_reset_outputs();
    @(posedge CLK); #1;
    RESET = 0;

    fetch(32'h40, 0, 0, -1, -1);
    fetch(32'h4C, 0, 0, -1, -1);
    fetch(32'h48, 0, 0, -1, -1);
    fetch(32'h240, 0, 0, -1, -1);
    fetch(32'h40, 0, 0, -1, -1);
    chk("plan_cnt_miss3", 32'(CNT_MISS), 3);
    fetch(32'h84, 3, 3, -1, -1);
    fetch(32'h88, 0, 0, -1, -1);
    idle_flush();
    fetch(32'h40, 0, 0, -1, -1);
    fetch(32'h40, 0, 0, 2, -1);
    fetch(32'h40, 0, 0, -1, -1);
    fetch(32'hC0, 0, 0, -1, 1);
    fetch(32'hC0, 0, 0, -1, -1);
    fetch(32'hC4, 0, 0, -1, -1);

    for (int it = 0; it < 400; it++) begin
      int r;
      r = int'($urandom % 32);
      if (r == 0)      idle_flush();
      else if (r == 1) idle_cycle();
      else if (r == 2) fetch(rand_pc(), 0, 3, -1, int'($urandom % WPL));
      else             fetch(rand_pc(), 0, 3, ($urandom % 8 == 0) ? int'($urandom % WPL) : -1, -1);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
